// File: rtl/config_chain_loader.sv
// config_chain_loader: takes bitstream words from a host over valid/ready and
// shifts them LSB-first into the FPGA configuration chain. It stops after
// exactly CHAIN_LENGTH bits and drops any surplus bits of the final word.
// Optional feature macro CONFIG_CHAIN_LOADER_CRC_EN adds a CRC-8 check:
// poly 0x07, init 0x00, MSB-first register, fed with every bit shifted.
// The word accepted after the chain is full carries the expected CRC.
module config_chain_loader #(
  parameter int WORD_WIDTH   = 8,
  parameter int CHAIN_LENGTH = 64
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [WORD_WIDTH-1:0] word_in,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  config_data_out,
  output logic                  config_shift_en,
  output logic                  busy,
  output logic                  config_done,
  output logic                  error
);

  localparam int CNT_W  = $clog2(CHAIN_LENGTH + 1);
  localparam int SCNT_W = $clog2(WORD_WIDTH + 1);

`ifdef CONFIG_CHAIN_LOADER_CRC_EN
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CHECK, S_DONE, S_ERROR} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DONE, S_ERROR} state_t;
`endif

  state_t                state_reg, state_next;
  logic [WORD_WIDTH-1:0] shift_reg, shift_next;
  logic [SCNT_W-1:0]     scnt_reg, scnt_next;    // bits still held in the shifter
  logic [CNT_W-1:0]      bit_cnt_reg, bit_cnt_next; // bits pushed into the chain
`ifdef CONFIG_CHAIN_LOADER_CRC_EN
  logic [7:0]            crc_reg, crc_next;
  logic                  crc_fb;
`endif

  logic shifting;
  logic last_chain_bit;
  logic more_than_one_left;
  logic fire;

  // A bit is presented to the chain whenever the shifter is non-empty in LOAD.
  always_comb begin
    shifting           = (state_reg == S_LOAD) && (scnt_reg != '0);
    last_chain_bit     = shifting && (bit_cnt_reg == CNT_W'(CHAIN_LENGTH - 1));
    // Remaining bits = CHAIN_LENGTH - bit_cnt; refill only if more than one remains.
    more_than_one_left = (bit_cnt_reg < CNT_W'(CHAIN_LENGTH - 1));
    word_ready         = 1'b0;
    if (state_reg == S_LOAD) begin
      word_ready = (scnt_reg == '0) ||
                   ((scnt_reg == SCNT_W'(1)) && more_than_one_left);
    end
`ifdef CONFIG_CHAIN_LOADER_CRC_EN
    if (state_reg == S_CHECK) begin
      word_ready = 1'b1;
    end
`endif
    fire            = word_valid && word_ready;
    config_shift_en = shifting;
    config_data_out = shifting && shift_reg[0];
`ifdef CONFIG_CHAIN_LOADER_CRC_EN
    busy            = (state_reg == S_LOAD) || (state_reg == S_CHECK);
    error           = (state_reg == S_ERROR);
`else
    busy            = (state_reg == S_LOAD);
    error           = 1'b0;
`endif
    config_done     = (state_reg == S_DONE);
  end

  // Next-state logic: shifting, word acceptance, bit counting and CRC.
  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    scnt_next    = scnt_reg;
    bit_cnt_next = bit_cnt_reg;
`ifdef CONFIG_CHAIN_LOADER_CRC_EN
    crc_next     = crc_reg;
    crc_fb       = crc_reg[7] ^ shift_reg[0];
`endif
    if (abort) begin
      // Chain keeps whatever it already holds; only the loader is reset.
      state_next = S_IDLE;
      scnt_next  = '0;
    end else begin
      case (state_reg)
        S_LOAD: begin
          if (shifting) begin
            shift_next   = shift_reg >> 1;
            scnt_next    = scnt_reg - SCNT_W'(1);
            bit_cnt_next = bit_cnt_reg + CNT_W'(1);
`ifdef CONFIG_CHAIN_LOADER_CRC_EN
            crc_next     = {crc_reg[6:0], 1'b0} ^ (crc_fb ? 8'h07 : 8'h00);
`endif
          end
          if (last_chain_bit) begin
            // Chain full: surplus bits of this word are dropped.
            scnt_next = '0;
`ifdef CONFIG_CHAIN_LOADER_CRC_EN
            state_next = S_CHECK;
`else
            state_next = S_DONE;
`endif
          end else if (fire) begin
            shift_next = word_in;
            scnt_next  = SCNT_W'(WORD_WIDTH);
          end
        end
`ifdef CONFIG_CHAIN_LOADER_CRC_EN
        S_CHECK: begin
          if (fire) begin
            state_next = (word_in[7:0] == crc_reg) ? S_DONE : S_ERROR;
          end
        end
`endif
        default: begin
          // IDLE, DONE and ERROR all restart a fresh load on start.
          if (start) begin
            state_next   = S_LOAD;
            scnt_next    = '0;
            bit_cnt_next = '0;
`ifdef CONFIG_CHAIN_LOADER_CRC_EN
            crc_next     = 8'h00;
`endif
          end
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_reg   <= S_IDLE;
      shift_reg   <= '0;
      scnt_reg    <= '0;
      bit_cnt_reg <= '0;
`ifdef CONFIG_CHAIN_LOADER_CRC_EN
      crc_reg     <= 8'h00;
`endif
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      scnt_reg    <= scnt_next;
      bit_cnt_reg <= bit_cnt_next;
`ifdef CONFIG_CHAIN_LOADER_CRC_EN
      crc_reg     <= crc_next;
`endif
    end
  end

endmodule

// File: tb/tb_config_chain_loader.sv
`timescale 1ns/1ps
module tb_config_chain_loader;
`ifdef CONFIG_CHAIN_LOADER_CRC_EN
  localparam int CL = 8;
`else
  localparam int CL = 12;
`endif

  logic       clock = 1'b0;
  logic       nreset;
  logic       start;
  logic       abort;
  logic [7:0] word_in;
  logic       word_valid;
  logic       word_ready;
  logic       config_data_out;
  logic       config_shift_en;
  logic       busy;
  logic       config_done;
  logic       error;

  int checks = 0;
  int fails  = 0;

  config_chain_loader #(.WORD_WIDTH(8), .CHAIN_LENGTH(CL)) dut (
    .clock          (clock),
    .nreset         (nreset),
    .start          (start),
    .abort          (abort),
    .word_in        (word_in),
    .word_valid     (word_valid),
    .word_ready     (word_ready),
    .config_data_out(config_data_out),
    .config_shift_en(config_shift_en),
    .busy           (busy),
    .config_done    (config_done),
    .error          (error)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  // Pulse start for one edge; returns on the following negedge.
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    @(negedge clock);
  endtask

  // Drives 0xA5 then 0x3C (optionally with a gap of 'gap' bubble cycles before
  // 0x3C) and records what the chain sees. Stops at config_done, or after
  // abort_after bits by asserting abort for one edge. Does no checking.
  task automatic collect(input int gap, input int abort_after,
                         output logic [11:0] bits, output int nbits,
                         output int bubbles, output int late_ready);
    int idx;
    idx = 0; bits = '0; nbits = 0; bubbles = 0; late_ready = 0;
    word_in = 8'hA5; word_valid = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (config_done) break;
      if (idx >= 2 && word_ready) late_ready++;
      if (config_shift_en) begin
        if (nbits < 12) bits[nbits] = config_data_out;
        nbits++;
      end else if (idx >= 1) begin
        bubbles++;
      end
      if (word_valid && word_ready) idx++;
      if (abort_after > 0 && nbits == abort_after) begin
        abort = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0; word_valid = 1'b0;
        @(negedge clock);
        $display("load aborted after %0d bits", nbits);
        return;
      end
      @(posedge clock); #1;
      case (idx)
        0: begin word_in = 8'hA5; word_valid = 1'b1; end
        1: begin word_in = 8'h3C; word_valid = (gap == 0) || (bubbles + 1 >= gap); end
        default: word_valid = 1'b0;
      endcase
      @(negedge clock);
    end
    word_valid = 1'b0;
    $display("load: %0d bits %03h, %0d bubbles", nbits, bits, bubbles);
  endtask

  task automatic test_reset();
    nreset = 1'b0; start = 1'b0; abort = 1'b0; word_valid = 1'b0; word_in = 8'h00;
    repeat (2) @(negedge clock);
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (word_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b expected 0", word_ready); end
    checks++; if (config_shift_en !== 1'b0) begin fails++; $display("FAIL reset_shift_en: got %b expected 0", config_shift_en); end
    checks++; if (config_done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", config_done); end
    checks++; if (error !== 1'b0) begin fails++; $display("FAIL reset_error: got %b expected 0", error); end
    nreset = 1'b1;
    word_valid = 1'b1; word_in = 8'hFF;   // IDLE must ignore valid
    repeat (2) @(negedge clock);
    checks++; if (word_ready !== 1'b0) begin fails++; $display("FAIL idle_ready: got %b expected 0", word_ready); end
    checks++; if (config_shift_en !== 1'b0) begin fails++; $display("FAIL idle_shift_en: got %b expected 0", config_shift_en); end
    word_valid = 1'b0;
    $display("reset test done");
  endtask

`ifndef CONFIG_CHAIN_LOADER_CRC_EN
  task automatic test_back_to_back();
    logic [11:0] bits, exp_bits;
    int n, bub, late;
    exp_bits = 12'hCA5;   // 0xA5 then low nibble of 0x3C, LSB-first
    pulse_start();
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_busy: got %b expected 1", busy); end
    checks++; if (word_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready: got %b expected 1", word_ready); end
    collect(0, 0, bits, n, bub, late);
    checks++; if (bits !== exp_bits) begin fails++; $display("FAIL b2b_bits: got %03h expected %03h", bits, exp_bits); end
    checks++; if (n !== 12) begin fails++; $display("FAIL b2b_nbits: got %0d expected 12", n); end
    checks++; if (bub !== 0) begin fails++; $display("FAIL b2b_bubbles: got %0d expected 0", bub); end
    checks++; if (late !== 0) begin fails++; $display("FAIL b2b_late_ready: got %0d expected 0", late); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_done_busy: got %b expected 0", busy); end
    word_valid = 1'b1; word_in = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      checks++; if (config_done !== 1'b1) begin fails++; $display("FAIL b2b_done_%0d: got %b expected 1", i, config_done); end
      checks++; if (word_ready !== 1'b0) begin fails++; $display("FAIL b2b_ready_after_%0d: got %b expected 0", i, word_ready); end
      @(negedge clock);
    end
    word_valid = 1'b0;
  endtask

  task automatic test_start_in_done();
    pulse_start();
    checks++; if (config_done !== 1'b0) begin fails++; $display("FAIL restart_done: got %b expected 0", config_done); end
    checks++; if (word_ready !== 1'b1) begin fails++; $display("FAIL restart_ready: got %b expected 1", word_ready); end
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL restart_busy: got %b expected 1", busy); end
  endtask

  task automatic test_valid_gaps();
    logic [11:0] bits, exp_bits;
    int n, bub, late;
    exp_bits = 12'hCA5;
    collect(3, 0, bits, n, bub, late);
    checks++; if (bits !== exp_bits) begin fails++; $display("FAIL gap_bits: got %03h expected %03h", bits, exp_bits); end
    checks++; if (n !== 12) begin fails++; $display("FAIL gap_nbits: got %0d expected 12", n); end
    checks++; if (bub !== 3) begin fails++; $display("FAIL gap_bubbles: got %0d expected 3", bub); end
    checks++; if (config_done !== 1'b1) begin fails++; $display("FAIL gap_done: got %b expected 1", config_done); end
  endtask

  task automatic test_abort();
    logic [11:0] bits, exp_bits;
    logic [4:0]  first5;
    int n, bub, late;
    exp_bits = 12'hCA5;
    pulse_start();
    collect(0, 5, bits, n, bub, late);
    first5 = bits[4:0];
    checks++; if (first5 !== 5'b00101) begin fails++; $display("FAIL abort_bits: got %b expected 00101", first5); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy: got %b expected 0", busy); end
    checks++; if (config_shift_en !== 1'b0) begin fails++; $display("FAIL abort_shift_en: got %b expected 0", config_shift_en); end
    checks++; if (config_done !== 1'b0) begin fails++; $display("FAIL abort_done: got %b expected 0", config_done); end
    checks++; if (word_ready !== 1'b0) begin fails++; $display("FAIL abort_ready: got %b expected 0", word_ready); end
    pulse_start();
    collect(0, 0, bits, n, bub, late);
    checks++; if (bits !== exp_bits) begin fails++; $display("FAIL reload_bits: got %03h expected %03h", bits, exp_bits); end
    checks++; if (n !== 12) begin fails++; $display("FAIL reload_nbits: got %0d expected 12", n); end
    checks++; if (config_done !== 1'b1) begin fails++; $display("FAIL reload_done: got %b expected 1", config_done); end
  endtask

  task automatic test_reset_mid_load();
    logic [11:0] bits, exp_bits;
    int n, bub, late;
    exp_bits = 12'hCA5;
    pulse_start();
    word_in = 8'hA5; word_valid = 1'b1;
    @(posedge clock); #1;
    word_valid = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (config_shift_en !== 1'b1) begin fails++; $display("FAIL midload_shifting: got %b expected 1", config_shift_en); end
    #2 nreset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL nreset_busy: got %b expected 0", busy); end
    checks++; if (config_shift_en !== 1'b0) begin fails++; $display("FAIL nreset_shift_en: got %b expected 0", config_shift_en); end
    checks++; if (config_data_out !== 1'b0) begin fails++; $display("FAIL nreset_data: got %b expected 0", config_data_out); end
    @(negedge clock);
    nreset = 1'b1;
    @(negedge clock);
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL post_reset_busy: got %b expected 0", busy); end
    pulse_start();
    collect(0, 0, bits, n, bub, late);
    checks++; if (bits !== exp_bits) begin fails++; $display("FAIL post_reset_bits: got %03h expected %03h", bits, exp_bits); end
    checks++; if (config_done !== 1'b1) begin fails++; $display("FAIL post_reset_done: got %b expected 1", config_done); end
  endtask
`else
  // Word 0x01 enters the chain LSB-first (1,0,0,0,0,0,0,0); CRC-8/0x07 of
  // that bit sequence is 0x89.
  task automatic test_crc(input logic [7:0] crc_word, input logic exp_done, input string tag);
    pulse_start();
    word_in = 8'h01; word_valid = 1'b1;
    @(posedge clock); #1;
    word_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (word_ready) break;
    end
    checks++; if (word_ready !== 1'b1) begin fails++; $display("FAIL %s_check_ready: got %b expected 1", tag, word_ready); end
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL %s_check_busy: got %b expected 1", tag, busy); end
    word_in = crc_word; word_valid = 1'b1;
    @(posedge clock); #1;
    word_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++; if (config_done !== exp_done) begin fails++; $display("FAIL %s_done_%0d: got %b expected %b", tag, i, config_done, exp_done); end
      checks++; if (error !== !exp_done) begin fails++; $display("FAIL %s_error_%0d: got %b expected %b", tag, i, error, !exp_done); end
    end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL %s_busy: got %b expected 0", tag, busy); end
    $display("crc word %02h -> done=%b error=%b", crc_word, config_done, error);
  endtask

  task automatic test_start_from_error();
    pulse_start();
    checks++; if (error !== 1'b0) begin fails++; $display("FAIL err_restart_error: got %b expected 0", error); end
    checks++; if (word_ready !== 1'b1) begin fails++; $display("FAIL err_restart_ready: got %b expected 1", word_ready); end
  endtask
`endif

  initial begin
    test_reset();
`ifndef CONFIG_CHAIN_LOADER_CRC_EN
    test_back_to_back();
    test_start_in_done();
    test_valid_gaps();
    test_abort();
    test_reset_mid_load();
`else
    test_crc(8'h89, 1'b1, "crc_good");
    test_crc(8'h08, 1'b0, "crc_bad");
    test_start_from_error();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
